// File: rtl/reg_file_output_selector.sv
// Read-side byte selector for the 16x16 register file. Each lane picks one byte,
// with per-byte forwarding from the decoder's write bus, behind a one-deep valid/ready output register.
module reg_file_output_selector #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned REG_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [1:0]                 rd_en,
  input  logic [9:0]                 rd_addr,
  input  logic [NUM_REGS*REG_W-1:0]  reg_data,
  input  logic [2*NUM_REGS-1:0]      wen,
  input  logic [NUM_REGS*REG_W-1:0]  wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [REG_W-1:0]           data_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned BYTE_IDX_W = IDX_W + 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic             accept;
  logic             consume;
  logic [7:0]       lane_a;
  logic [7:0]       lane_b;
  logic [REG_W-1:0] next_data;

  // Lane select is {byte, reg}; the flat byte index is {reg, byte}, which is
  // also the matching wen bit, so one index serves both buses.
  function automatic logic [7:0] lane_byte(
    input logic                          en,
    input logic [BYTE_IDX_W-1:0]         sel,
    input logic [NUM_REGS*REG_W-1:0]     rdata,
    input logic [2*NUM_REGS-1:0]         we,
    input logic [NUM_REGS*REG_W-1:0]     wdata
  );
    logic [BYTE_IDX_W-1:0] k;
    k = {sel[IDX_W-1:0], sel[IDX_W]};
    if (!en) begin
      return '0;
    end
    if (we[k]) begin
      return wdata[{k, 3'b000} +: 8];
    end
    return rdata[{k, 3'b000} +: 8];
  endfunction

  always_comb begin
    lane_a    = lane_byte(rd_en[0], rd_addr[BYTE_IDX_W-1:0], reg_data, wen, wr_data);
    lane_b    = lane_byte(rd_en[1], rd_addr[2*BYTE_IDX_W-1:BYTE_IDX_W], reg_data, wen, wr_data);
    next_data = {lane_b, lane_a};
  end

  always_comb begin
    rd_ready = (state == EMPTY) | out_ready;
    accept   = rd_valid & rd_ready;
    consume  = (state == FULL) & out_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (accept) next_state = FULL;
      FULL:  if (consume && !accept) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
  end

  // Captured only on accept, so a stalled result is a snapshot immune to later writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (accept) begin
      data_out <= next_data;
    end
  end

endmodule

// File: tb/tb_reg_file_output_selector.sv
// Scoreboard bench for reg_file_output_selector: directed scenarios followed by
// randomized traffic, checked against a word-level reference model.
module tb_reg_file_output_selector;

  logic         clock;
  logic         reset_n;
  logic         rd_valid;
  logic         rd_ready;
  logic [1:0]   rd_en;
  logic [9:0]   rd_addr;
  logic [255:0] reg_data;
  logic [31:0]  wen;
  logic [255:0] wr_data;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  data_out;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  logic        exp_full;

  reg_file_output_selector #(.NUM_REGS(16), .REG_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .reg_data(reg_data), .wen(wen),
    .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: whole register word chosen from the write bus if that byte is written, then the byte extracted.
  function automatic logic [7:0] ref_lane(input logic en, input int r, input int b,
                                          input logic [255:0] rd, input logic [31:0] w,
                                          input logic [255:0] wd);
    logic [15:0] word;
    if (!en) return 8'h00;
    word = w[2*r+b] ? wd[16*r +: 16] : rd[16*r +: 16];
    return (b == 1) ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [9:0] addr(input int a_reg, input int a_byte, input int b_reg, input int b_byte);
    logic [9:0] v;
    v[3:0] = 4'(a_reg);
    v[4]   = 1'(a_byte);
    v[8:5] = 4'(b_reg);
    v[9]   = 1'(b_byte);
    return v;
  endfunction

  // Handshake occupancy model of a one-deep output buffer.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_full <= 1'b0;
      exp_q.delete();
    end else if (rd_valid && (!exp_full || out_ready)) begin
      exp_full <= 1'b1;
    end else if (out_ready) begin
      exp_full <= 1'b0;
    end
  end

  // Issue side: push the expected word for every request that will be accepted.
  always @(negedge clock) begin
    if (reset_n && rd_valid && (!exp_full || out_ready)) begin
      exp_q.push_back({ref_lane(rd_en[1], int'(rd_addr[8:5]), int'(rd_addr[9]), reg_data, wen, wr_data),
                       ref_lane(rd_en[0], int'(rd_addr[3:0]), int'(rd_addr[4]), reg_data, wen, wr_data)});
    end
  end

  // Monitor: compare handshake signals every cycle, pop on each consumed result.
  always @(negedge clock) begin
    if (reset_n) begin
      check("rd_ready", 32'(rd_ready), 32'(!exp_full || out_ready));
      check("out_valid", 32'(out_valid), 32'(exp_full));
      if (exp_full && out_ready && out_valid) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_reg(input int r, input logic [15:0] v);
    reg_data[16*r +: 16] = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rd_valid = 1'b0; rd_en = 2'b00; rd_addr = '0;
    reg_data = '0; wen = '0; wr_data = '0; out_ready = 1'b1;
    repeat (2) step();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data_out", 32'(data_out), 32'h0000);
    reset_n = 1'b1;
    step();

    // Full word read of reg3.
    set_reg(3, 16'hBEEF);
    rd_addr = addr(3, 0, 3, 1); rd_en = 2'b11; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(data_out), 32'hBEEF);
    step();

    // Cross-register bytes and a disabled lane.
    set_reg(5, 16'h1234); set_reg(9, 16'hABCD);
    rd_addr = addr(9, 1, 5, 0); rd_en = 2'b11; rd_valid = 1'b1;
    step();
    check("t2_data", 32'(data_out), 32'h34AB);
    rd_en = 2'b01;
    step();
    rd_valid = 1'b0;
    check("t2_lane_off", 32'(data_out), 32'h00AB);
    rd_en = 2'b00; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    check("t2_both_off", 32'(data_out), 32'h0000);

    // Forwarding of the high byte only.
    set_reg(2, 16'h0011);
    wen = 32'h0000_0020; wr_data[16*2 +: 16] = 16'h7700;
    rd_addr = addr(2, 1, 2, 0); rd_en = 2'b11; rd_valid = 1'b1;
    step();
    rd_valid = 1'b0; wen = '0;
    check("t3_forward", 32'(data_out), 32'h1177);
    step();

    // Stall with a held snapshot while writes hit its source.
    rd_addr = addr(3, 0, 3, 1); rd_en = 2'b11; rd_valid = 1'b1;
    step();
    out_ready = 1'b0; rd_addr = addr(9, 0, 9, 1);
    wen = 32'h0000_00C0; wr_data[16*3 +: 16] = 16'h5A5A;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("t4_stall_ready", 32'(rd_ready), 32'd0);
      check("t4_stall_data", 32'(data_out), 32'hBEEF);
    end
    wen = '0; out_ready = 1'b1; rd_addr = addr(5, 0, 5, 1);
    step();
    rd_valid = 1'b0;
    check("t4_release", 32'(data_out), 32'h1234);
    step();

    // Streaming reg0..reg7 as full words.
    for (int r = 0; r < 8; r++) set_reg(r, 16'(16'h1111 * r));
    for (int r = 0; r < 8; r++) begin
      rd_addr = addr(r, 0, r, 1); rd_en = 2'b11; rd_valid = 1'b1;
      step();
      check("t5_stream", 32'(data_out), 32'(16'h1111 * r));
    end
    rd_valid = 1'b0;
    step();

    // Asynchronous reset while stalled.
    rd_addr = addr(3, 0, 3, 1); rd_valid = 1'b1;
    step();
    rd_valid = 1'b0; out_ready = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_data", 32'(data_out), 32'h0000);
    reset_n = 1'b1;
    check("t6_ready_after", 32'(rd_ready), 32'd1);
    step();
    out_ready = 1'b1; rd_addr = addr(9, 0, 9, 1); rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    check("t6_after_reset", 32'(data_out), 32'hABCD);
    step();

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        reg_data[32*k +: 32] = $urandom;
        wr_data[32*k +: 32]  = $urandom;
      end
      wen       = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
      rd_addr   = 10'($urandom);
      rd_en     = 2'($urandom);
      rd_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rd_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
